fmac_sched: RTL and testbench

- Sequencer that computes a floating-point dot product sum(a_i*b_i) over a stream of operand pairs, using one externally shared fmul core and one fadd core.
- Replaces hand-built one-hot state sequencing around the fmul/fadd IP cores.
- Handles pipeline-latency bookkeeping, operand back-pressure and the accumulator feedback loop.
- Sits between a producer of operand pairs (valid/ready) and a consumer of the scalar result (valid/ready).

---
 rtl/fmac_sched.sv | 119 +++++++++++
 tb/tb_fmac_sched.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fmac_sched.sv
// rtl/fmac_sched.sv - dot-product sequencer driving shared fmul/fadd cores
// Products land in a small FIFO and are folded into acc one add at a time.
module fmac_sched #(
  parameter int WIDTH      = 11,
  parameter int MUL_LAT    = 2,
  parameter int ADD_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             busy,
  output logic [WIDTH-1:0] fmul_x,
  output logic [WIDTH-1:0] fmul_y,
  output logic             fmul_ce,
  input  logic [WIDTH-1:0] fmul_r,
  output logic [WIDTH-1:0] fadd_x,
  output logic [WIDTH-1:0] fadd_y,
  output logic             fadd_ce,
  input  logic [WIDTH-1:0] fadd_r
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int AW = $clog2(ADD_LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state, state_n;
  logic [MUL_LAT-1:0] tags;
  logic [CW-1:0]      occ, occ_n, inflight, inflight_n;
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]      add_cnt;
  logic [WIDTH-1:0]   acc;
  logic               acc_valid;
  logic               accept, push, pop, add_issue, room_n;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign accept     = in_valid && in_ready;
  assign push       = tags[MUL_LAT-1];
  // A pop either seeds acc (first product) or launches the single outstanding add.
  assign pop        = (occ != '0) && (add_cnt == '0);
  assign add_issue  = pop && acc_valid;
  assign occ_n      = occ + CW'(push) - CW'(pop);
  assign inflight_n = inflight + CW'(accept) - CW'(push);
  assign room_n     = ({1'b0, occ_n} + {1'b0, inflight_n}) < (CW + 1)'(FIFO_DEPTH);

  assign fmul_ce = accept || (state == RUN) || (state == DRAIN);
  assign fmul_x  = accept ? in_a : '0;
  assign fmul_y  = accept ? in_b : '0;
  assign fadd_ce = add_issue || (add_cnt != '0);
  assign fadd_x  = add_issue ? acc : '0;
  assign fadd_y  = add_issue ? mem[rd_ptr] : '0;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = in_last ? DRAIN : RUN;
      RUN:     if (accept && in_last) state_n = DRAIN;
      DRAIN:   if (occ == '0 && inflight == '0 && add_cnt == '0) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= fmul_r;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      tags       <= '0;
      occ        <= '0;
      inflight   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      add_cnt    <= '0;
      acc        <= '0;
      acc_valid  <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      busy       <= 1'b0;
    end else begin
      state    <= state_n;
      tags     <= (tags << 1) | MUL_LAT'(accept);
      occ      <= occ_n;
      inflight <= inflight_n;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (pop && !acc_valid) begin
        acc       <= mem[rd_ptr];
        acc_valid <= 1'b1;
      end
      if (add_issue) begin
        add_cnt <= AW'(ADD_LAT);
      end else if (add_cnt != '0) begin
        add_cnt <= add_cnt - 1'b1;
        if (add_cnt == AW'(1)) acc <= fadd_r;
      end
      if (state == DONE && out_ready) acc_valid <= 1'b0;
      in_ready   <= (state_n == IDLE) || (state_n == RUN && room_n);
      out_valid  <= (state_n == DONE);
      out_result <= (state_n == DONE) ? acc : '0;
      busy       <= (state_n != IDLE);
    end
  end
endmodule

// File: tb/tb_fmac_sched.sv
// tb/tb_fmac_sched.sv - randomized self-checking bench for fmac_sched
// Behavioural fmul/fadd cores and a sequential-fold dot product reference.
module tb_fmac_sched;
  localparam int WIDTH = 11, MUL_LAT = 2, ADD_LAT = 1, FIFO_DEPTH = 4;

  logic clk = 1'b0, reset = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [WIDTH-1:0] in_a = '0, in_b = '0;
  logic in_ready, out_valid, busy, fmul_ce, fadd_ce;
  logic [WIDTH-1:0] out_result, fmul_x, fmul_y, fadd_x, fadd_y, fmul_r, fadd_r;
  logic [WIDTH-1:0] mul_pipe [MUL_LAT];
  logic [WIDTH-1:0] add_pipe [ADD_LAT];
  logic [WIDTH-1:0] va [16], vb [16];
  int vectors = 0, miscompares = 0, cyc = 0, fadd_seen = 0, stall_seen = 0;

  fmac_sched #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .busy(busy),
    .fmul_x(fmul_x), .fmul_y(fmul_y), .fmul_ce(fmul_ce), .fmul_r(fmul_r),
    .fadd_x(fadd_x), .fadd_y(fadd_y), .fadd_ce(fadd_ce), .fadd_r(fadd_r)
  );

  always #5 clk = ~clk;

  // Format: 2 exception bits, sign, 4-bit exponent (bias 7), 4-bit fraction.
  function automatic real fp_dec(input logic [WIDTH-1:0] v);
    real m;
    m = 1.0 + real'(v[3:0]) / 16.0;
    if (v[10:9] != 2'b01) return 0.0;
    for (int i = 0; i < int'(v[7:4]); i++) m = m * 2.0;
    for (int i = 0; i < 7; i++) m = m / 2.0;
    return v[8] ? -m : m;
  endfunction

  function automatic logic [WIDTH-1:0] fp_enc(input real x);
    real m;
    int e, f;
    logic s;
    if (x == 0.0) return '0;
    s = (x < 0.0);
    m = s ? -x : x;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    f = int'($floor((m - 1.0) * 16.0 + 0.5));
    if (f == 16) begin f = 0; e++; end
    if (e + 7 > 15) return {2'b10, s, 8'h00};
    if (e + 7 < 0) return '0;
    return {2'b01, s, 4'(e + 7), 4'(f)};
  endfunction

  function automatic logic [WIDTH-1:0] fp_mul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return fp_enc(fp_dec(x) * fp_dec(y));
  endfunction

  function automatic logic [WIDTH-1:0] fp_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return fp_enc(fp_dec(x) + fp_dec(y));
  endfunction

  function automatic logic [WIDTH-1:0] rand_fp();
    return {2'b01, 1'($urandom_range(0, 1)), 4'($urandom_range(5, 8)), 4'($urandom_range(0, 15))};
  endfunction

  // Dot product accumulated strictly in arrival order.
  function automatic logic [WIDTH-1:0] ref_dot(input int n);
    logic [WIDTH-1:0] acc;
    acc = fp_mul(va[0], vb[0]);
    for (int i = 1; i < n; i++) acc = fp_add(acc, fp_mul(va[i], vb[i]));
    return acc;
  endfunction

  always @(posedge clk) begin
    if (fmul_ce) begin
      mul_pipe[0] <= fp_mul(fmul_x, fmul_y);
      for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
    end
    if (fadd_ce) begin
      add_pipe[0] <= fp_add(fadd_x, fadd_y);
      for (int i = 1; i < ADD_LAT; i++) add_pipe[i] <= add_pipe[i-1];
    end
  end
  assign fmul_r = mul_pipe[MUL_LAT-1];
  assign fadd_r = add_pipe[ADD_LAT-1];

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (fadd_ce) fadd_seen++;
    if (in_valid && !in_ready && busy) stall_seen++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic last,
                           output int acc_cyc);
    int t;
    t = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) check_eq("accept_timeout", 0, 1);
    acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic run_vector(input int n, input int gap_max, input int hold, input bit chk_lat,
                            input string tag, input logic [WIDTH-1:0] exp);
    logic [WIDTH-1:0] held;
    int first_cyc, c, t, f0;
    first_cyc = 0;
    f0 = fadd_seen;
    for (int i = 0; i < n; i++) begin
      send_pair(va[i], vb[i], (i == n - 1), c);
      if (i == 0) first_cyc = c;
      if (i != n - 1 && gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
    end
    t = 0;
    while (!out_valid && t < 300) begin @(negedge clk); t++; end
    if (!out_valid) begin
      check_eq({tag, "_timeout"}, 0, 1);
      return;
    end
    if (chk_lat)
      check_eq({tag, "_latency"}, 32'((cyc - first_cyc) <= n + MUL_LAT + (n - 1) * (ADD_LAT + 1) + 2), 1);
    check_eq({tag, "_result"}, 32'(out_result), 32'(exp));
    if (n == 1) check_eq({tag, "_fadd_ce_cycles"}, 32'(fadd_seen - f0), 0);
    held = out_result;
    repeat (hold) begin
      @(negedge clk);
      check_eq({tag, "_hold_valid"}, 32'(out_valid), 1);
      check_eq({tag, "_hold_result"}, 32'(out_result), 32'(held));
      check_eq({tag, "_hold_in_ready"}, 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_drop_valid"}, 32'(out_valid), 0);
    check_eq({tag, "_idle_busy"}, 32'(busy), 0);
    check_eq({tag, "_idle_in_ready"}, 32'(in_ready), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 0);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_fmul_ce"}, 32'(fmul_ce), 0);
    check_eq({tag, "_fadd_ce"}, 32'(fadd_ce), 0);
    check_eq({tag, "_out_result"}, 32'(out_result), 0);
    check_eq({tag, "_operands"}, 32'(fmul_x | fmul_y | fadd_x | fadd_y), 0);
  endtask

  initial begin
    int c, n, s0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);
    check_eq("idle_in_ready", 32'(in_ready), 1);

    va[0] = 11'b01001110000; vb[0] = 11'b01010000000;
    va[1] = 11'b01010001000; vb[1] = 11'b01010010000;
    va[2] = 11'b01010010100; vb[2] = 11'b01010011000;
    va[3] = 11'b01010011100; vb[3] = 11'b01010100000;
    run_vector(4, 0, 10, 1'b1, "dot4", 11'b01011011001);

    va[0] = 11'b01001110000; vb[0] = 11'b01010000000;
    run_vector(1, 0, 10, 1'b1, "single", 11'b01010000000);

    va[0] = 11'b01010001000; vb[0] = 11'b01010010000;
    run_vector(1, 0, 2, 1'b1, "vec2", 11'b01010101000);

    for (int i = 0; i < 8; i++) begin va[i] = rand_fp(); vb[i] = rand_fp(); end
    s0 = stall_seen;
    run_vector(8, 0, 1, 1'b0, "stream8", ref_dot(8));
    check_eq("stream8_backpressure", 32'(stall_seen > s0), 1);

    send_pair(rand_fp(), rand_fp(), 1'b0, c);
    send_pair(rand_fp(), rand_fp(), 1'b0, c);
    reset = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    va[0] = 11'b01001110000; vb[0] = 11'b01010000000;
    run_vector(1, 0, 3, 1'b1, "post_reset", 11'b01010000000);

    for (int k = 0; k < 10; k++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin va[i] = rand_fp(); vb[i] = rand_fp(); end
      run_vector(n, 3, $urandom_range(0, 3), 1'b0, "random", ref_dot(n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
